// File: rtl/inst_fetch_ctrl_pkg.sv
// rtl/inst_fetch_ctrl_pkg.sv - shared constants, state encoding and word-align bits for inst_fetch_ctrl
package inst_fetch_ctrl_pkg;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   localparam int unsigned IFC_ADDR_W = 32;
   localparam int unsigned IFC_DATA_W = 32;
   localparam logic [IFC_ADDR_W-1:0] IFC_RESET_PC = 32'h0000_0000;

   // Low address bits forced by the word-align mask on every ROM access
   localparam logic [1:0] IFC_WORD_ALIGN_LO = 2'b00;

   typedef enum logic [1:0] {
      IFC_BOOT  = 2'd0,
      IFC_FETCH = 2'd1,
      IFC_DBG   = 2'd2
   } ifc_state_e;

endpackage

// File: rtl/inst_fetch_ctrl_dbg_arb.sv
// rtl/inst_fetch_ctrl_dbg_arb.sv - debug starvation counter and grant decision for the shared ROM
module ifc_dbg_arb
   import inst_fetch_ctrl_pkg::*;
#(
   parameter int unsigned DBG_MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic dbg_req,
   input  logic stall,
   input  logic in_fetch,
   input  logic redirect,
   output logic grant
);

   localparam logic [3:0] MAX_WAIT = 4'(DBG_MAX_WAIT);

   logic [3:0] wait_q;
   logic [3:0] wait_d;

   // A stalled pipeline leaves the ROM idle, so debug may take it without delaying fetch
   always_comb begin
      grant  = in_fetch & ~redirect & dbg_req & (stall | (wait_q == MAX_WAIT));
      wait_d = wait_q;
      if (!dbg_req || grant) begin
         wait_d = '0;
      end else if (in_fetch && (wait_q != MAX_WAIT)) begin
         wait_d = wait_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - PC sequencer sharing the instruction ROM with a debug port; IFC_PERF_CNT_EN adds perf counters
module inst_fetch_ctrl
   import inst_fetch_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W       = IFC_ADDR_W,
   parameter int unsigned DATA_W       = IFC_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFC_RESET_PC),
   parameter int unsigned DBG_MAX_WAIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_data_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [DATA_W-1:0] inst_o,
   output logic              inst_valid_o,
   input  logic              dbg_req_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   output logic              dbg_ack_o,
   output logic [DATA_W-1:0] dbg_data_o
`ifdef IFC_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_cnt_o,
   output logic [31:0]       bubble_cnt_o
`endif
);

   ifc_state_e        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;
   logic [DATA_W-1:0] inst_q, inst_d;
   logic              inst_valid_q, inst_valid_d;
   logic              dbg_ack_q, dbg_ack_d;
   logic [DATA_W-1:0] dbg_data_q, dbg_data_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              rom_ce_d;
   logic              grant;

   ifc_dbg_arb #(
      .DBG_MAX_WAIT(DBG_MAX_WAIT)
   ) u_dbg_arb (
      .clk     (clk),
      .rst     (rst),
      .dbg_req (dbg_req_i),
      .stall   (stall_i),
      .in_fetch(state_q == IFC_FETCH),
      .redirect(redirect_i),
      .grant   (grant)
   );

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      pc_out_d     = pc_out_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      dbg_ack_d    = 1'b0;
      dbg_data_d   = dbg_data_q;
      rom_ce_d     = DISABLE;
      rom_addr_d   = rom_addr_q;

      case (state_q)
         IFC_BOOT: begin
            state_d = IFC_FETCH;
         end
         IFC_FETCH: begin
            if (redirect_i) begin
               pc_d         = {redirect_pc_i[ADDR_W-1:2], IFC_WORD_ALIGN_LO};
               inst_valid_d = 1'b0;
            end else if (grant) begin
               rom_ce_d   = ENABLE;
               rom_addr_d = {dbg_addr_i[ADDR_W-1:2], IFC_WORD_ALIGN_LO};
               dbg_data_d = rom_data_i;
               dbg_ack_d  = 1'b1;
               state_d    = IFC_DBG;
               if (!stall_i) begin
                  inst_valid_d = 1'b0;
               end
            end else if (!stall_i) begin
               rom_ce_d     = ENABLE;
               rom_addr_d   = pc_q;
               inst_d       = rom_data_i;
               pc_out_d     = pc_q;
               inst_valid_d = 1'b1;
               pc_d         = pc_q + ADDR_W'(4);
            end
         end
         IFC_DBG: begin
            // ROM stays idle here so the ack cycle never carries a fetch
            state_d = IFC_FETCH;
            if (redirect_i) begin
               pc_d         = {redirect_pc_i[ADDR_W-1:2], IFC_WORD_ALIGN_LO};
               inst_valid_d = 1'b0;
            end else if (!stall_i) begin
               inst_valid_d = 1'b0;
            end
         end
         default: begin
            state_d = IFC_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IFC_BOOT;
         pc_q         <= RESET_PC;
         pc_out_q     <= RESET_PC;
         inst_q       <= '0;
         inst_valid_q <= 1'b0;
         dbg_ack_q    <= 1'b0;
         dbg_data_q   <= '0;
         rom_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         pc_out_q     <= pc_out_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         dbg_ack_q    <= dbg_ack_d;
         dbg_data_q   <= dbg_data_d;
         rom_addr_q   <= rom_addr_d;
      end
   end

   assign rom_ce_o     = rom_ce_d;
   assign rom_addr_o   = rom_addr_d;
   assign pc_o         = pc_out_q;
   assign inst_o       = inst_q;
   assign inst_valid_o = inst_valid_q;
   assign dbg_ack_o    = dbg_ack_q;
   assign dbg_data_o   = dbg_data_q;

`ifdef IFC_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;
   logic        capture;
   logic        bubble;

   // Bubbles are lost capture slots not explained by the pipeline holding
   always_comb begin
      capture      = (state_q == IFC_FETCH) && !redirect_i && !grant && !stall_i;
      bubble       = (state_q != IFC_BOOT) && !capture && (redirect_i || !stall_i);
      fetch_cnt_d  = fetch_cnt_q + (capture ? 32'd1 : 32'd0);
      bubble_cnt_d = bubble_cnt_q + (bubble ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign fetch_cnt_o  = fetch_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
Sequences the instruction ROM and shares it between the CPU fetch stage and a debug/loader read port. The ROM is combinational, read 32 bits per access, with ce gating.
- Owns the PC register and drives ROM ce/addr.
- Registers fetched words into the IF/ID boundary.
- Handles stall, branch/jump redirect and debug arbitration.
- Sits between the PC/branch logic and the IF/ID pipeline register.

Parameters:
- ADDR_W, 32, width of PC and ROM address.
- DATA_W, 32, instruction width (one ROM access).
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- DBG_MAX_WAIT, 4, max cycles a pending debug request is starved by fetch before forced grant (1..15).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall_i  in  1  pipeline stall: hold PC and IF/ID outputs
- redirect_i  in  1  branch/jump taken: load redirect_pc_i
- redirect_pc_i  in  ADDR_W  redirect target
- rom_ce_o  out  1  ROM chip enable (1 = read)
- rom_addr_o  out  ADDR_W  ROM byte address
- rom_data_i  in  DATA_W  ROM read data, valid same cycle as ce/addr
- pc_o  out  ADDR_W  address of inst_o
- inst_o  out  DATA_W  fetched instruction to IF/ID
- inst_valid_o  out  1  inst_o is a real instruction (0 = bubble)
- dbg_req_i  in  1  debug read request, level, held until ack
- dbg_addr_i  in  ADDR_W  debug read address, stable while req high
- dbg_ack_o  out  1  one-cycle pulse, dbg_data_o valid
- dbg_data_o  out  DATA_W  debug read data, held until next ack

Behaviour:
- Reset: state=BOOT, pc=RESET_PC, pc_o=RESET_PC, inst_o=0, inst_valid_o=0, rom_ce_o=0, rom_addr_o=0, dbg_ack_o=0, dbg_data_o=0, wait counter=0.
- States: BOOT, FETCH, DBG.
  - BOOT lasts exactly one cycle with ce=0, then goes to FETCH.
- FETCH, per cycle, in priority order:
  - redirect_i=1: rom_ce_o=0. Next pc = {redirect_pc_i[ADDR_W-1:2],2'b00}. inst_valid_o<=0 (flush). Redirect beats stall and debug.
  - Debug grant: dbg_req_i=1 and (stall_i=1 or wait counter==DBG_MAX_WAIT). Drive rom_addr_o={dbg_addr_i[ADDR_W-1:2],2'b00}, rom_ce_o=1. Latch dbg_data_o<=rom_data_i and pulse dbg_ack_o for the next cycle. Go to DBG. pc and IF/ID outputs hold; if stall_i=0, inst_valid_o<=0 (bubble).
  - stall_i=1, no debug grant: rom_ce_o=0; pc, pc_o, inst_o, inst_valid_o hold.
  - Otherwise: rom_ce_o=1, rom_addr_o=pc. Capture inst_o<=rom_data_i, pc_o<=pc, inst_valid_o<=1, pc<=pc+4. PC wraps modulo 2^ADDR_W with no flag.
- DBG: one cycle with dbg_ack_o=1. rom_ce_o=0, no fetch, returns to FETCH. IF/ID outputs hold if stall_i=1, else inst_valid_o<=0. redirect_i in DBG loads pc, identical to FETCH.
- Wait counter:
  - Increments each FETCH cycle with dbg_req_i=1 and no grant.
  - Clears on grant or when dbg_req_i=0; saturates at DBG_MAX_WAIT.
  - Guarantees a debug read within DBG_MAX_WAIT+1 cycles.
- Debug requester samples ack. Back-to-back requests are allowed; the minimum period is 2 cycles per debug read.
- Combinational outputs rom_ce_o/rom_addr_o: when ce=0, addr holds its last value (no X/Z).
- Reset asserted mid-DBG or mid-stall: all state returns to reset values next edge; no ack is issued.

Optional Feature:
- Macro IFC_PERF_CNT_EN.
- When defined:
  - Adds output fetch_cnt_o [31:0]: count of cycles with inst_valid_o 0->/1 captures, i.e. cycles that took the Otherwise branch.
  - Adds output bubble_cnt_o [31:0]: count of cycles with no capture for stall-free reasons (redirect, debug).
  - Both counters reset to 0 and wrap.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared header (alongside the existing ROM defines):
  - ENABLE/DISABLE
  - state encodings IFC_BOOT/IFC_FETCH/IFC_DBG
  - ADDR_W/DATA_W defaults and RESET_PC
  - word-align mask
- One sub-module: ifc_dbg_arb, which holds the wait counter and grant decision (inputs dbg_req, stall, in_fetch; output grant).

Test Plan:
- Reset, then free run with rom word at addr n = n: BOOT 1 cycle; then inst_o=0,4,8 at pc_o=0,4,8 on consecutive cycles, inst_valid_o=1.
- Redirect to 0x103 at pc=0x10 with stall_i=1 simultaneously: next cycle inst_valid_o=0, then pc_o=0x100, next 0x104.
- stall_i high 3 cycles with no debug request: rom_ce_o=0, pc_o/inst_o unchanged for all 3 cycles, resume at next sequential pc.
- dbg_req_i=1 at addr 0x20 with stall_i=0 and DBG_MAX_WAIT=4: 4 fetches complete, then grant; dbg_ack_o pulse carries rom[0x20]; one bubble; fetch resumes at the correct pc.
- dbg_req_i during stall: granted same cycle, ack next cycle, zero starvation; pc unchanged after stall drops.
- PC at 0xFFFF_FFFC with no stall: next pc=0x0000_0000. rst asserted during DBG: no ack, all outputs at reset values.
